// File: rtl/toy_fetch_realign.sv
// Realigns 32-bit fetch words into RV32IC instructions (16/32-bit, including
// 32-bit instructions that straddle two words) for the fetch stage.
module toy_fetch_realign #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear,
  input  logic                     clear_half,
  input  logic                     req_vld,
  output logic                     req_rdy,
  input  logic [31:0]              req_pld,
  output logic                     ack_vld,
  input  logic                     ack_rdy,
  output logic [31:0]              ack_pld,
  output logic                     ack_len,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0] TWO_C   = (AW+1)'(2);

  logic [31:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] rd_nxt;
  logic [AW:0]   count_q, count_d;
  logic          rd_half_q, rd_half_d;

  logic [31:0] head, nxt;
  logic [15:0] p0;
  logic        is32, ready, push, pop, take;

  always_comb begin
    rd_nxt = rd_ptr_q + AW'(1);
    head   = mem_q[rd_ptr_q];
    nxt    = mem_q[rd_nxt];
    p0     = rd_half_q ? head[31:16] : head[15:0];
    is32   = (p0[1:0] == 2'b11);
    // A straddling 32-bit instruction needs its second word already buffered.
    ready  = (count_q != '0) && (!(is32 && rd_half_q) || (count_q >= TWO_C));
  end

  assign req_rdy = (count_q < DEPTH_C);
  assign push    = req_vld && req_rdy;
  assign ack_vld = ready && !clear;
  assign take    = ack_vld && ack_rdy;
  assign pop     = take && (is32 || rd_half_q);
  assign count   = count_q;

  always_comb begin
    ack_pld = 32'h0;
    ack_len = 1'b0;
    if (ack_vld) begin
      ack_len = is32;
      if (!is32)         ack_pld = {16'h0, p0};
      else if (rd_half_q) ack_pld = {nxt[15:0], head[31:16]};
      else               ack_pld = head;
    end
  end

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    rd_half_d = rd_half_q;
    if (clear) begin
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      count_d   = '0;
      rd_half_d = clear_half;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_nxt;
      count_d = count_q + (AW+1)'(push) - (AW+1)'(pop);
      // Only 16-bit parcels move the halfword pointer; 32-bit keeps parity.
      if (take && !is32) rd_half_d = !rd_half_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      rd_half_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      rd_half_q <= rd_half_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !clear) mem_q[wr_ptr_q] <= req_pld;
  end

endmodule

// File: tb/tb_toy_fetch_realign.sv
// Scoreboard bench for toy_fetch_realign: directed words in, expected
// {len, instruction} queued at issue, monitor compares every accepted ack.
module tb_toy_fetch_realign;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clear = 1'b0;
  logic        clear_half = 1'b0;
  logic        req_vld = 1'b0;
  logic        req_rdy;
  logic [31:0] req_pld = 32'h0;
  logic        ack_vld;
  logic        ack_rdy = 1'b0;
  logic [31:0] ack_pld;
  logic        ack_len;
  logic [$clog2(DEPTH):0] count;

  int n_chk  = 0;
  int n_pass = 0;
  logic [32:0] sb [$];

  toy_fetch_realign #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .clear_half(clear_half),
    .req_vld(req_vld), .req_rdy(req_rdy), .req_pld(req_pld),
    .ack_vld(ack_vld), .ack_rdy(ack_rdy), .ack_pld(ack_pld),
    .ack_len(ack_len), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [32:0] act, input logic [32:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Monitor: every accepted instruction must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n && ack_vld && ack_rdy) begin
      if (sb.size() == 0) chk("unexpected_ack", {ack_len, ack_pld}, 33'h0);
      else chk("ack", {ack_len, ack_pld}, sb.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [31:0] w);
    req_vld = 1'b1;
    req_pld = w;
    tick();
    req_vld = 1'b0;
  endtask

  task automatic drain();
    int k = 0;
    while (sb.size() != 0 && k < 50) begin
      @(posedge clk);
      k++;
    end
    #1;
    chk("drain_left", 33'(sb.size()), 33'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Reset values
    #3;
    chk("rst_req_rdy", 33'(req_rdy), 33'h1);
    chk("rst_ack_vld", 33'(ack_vld), 33'h0);
    chk("rst_ack_pld", 33'(ack_pld), 33'h0);
    chk("rst_ack_len", 33'(ack_len), 33'h0);
    chk("rst_count",   33'(count),   33'h0);
    tick();
    rst_n = 1'b1;
    tick();

    // Aligned stream, 1-cycle push-to-ack latency
    ack_rdy = 1'b1;
    req_vld = 1'b1;
    req_pld = 32'h0000_0013;
    sb.push_back({1'b1, 32'h0000_0013});
    tick();
    req_pld = 32'h0010_0093;
    sb.push_back({1'b1, 32'h0010_0093});
    @(negedge clk);
    chk("latency_ack_vld", 33'(ack_vld), 33'h1);
    tick();
    req_vld = 1'b0;
    drain();

    // Compressed pair in one word
    ack_rdy = 1'b0;
    sb.push_back({1'b0, 32'h0000_4505});
    sb.push_back({1'b0, 32'h0000_4501});
    push_word(32'h4501_4505);
    @(negedge clk);
    chk("pair_count1", 33'(count), 33'h1);
    chk("pair_pld_held", 33'(ack_pld), 33'h4505);
    ack_rdy = 1'b1;
    drain();
    chk("pair_count0", 33'(count), 33'h0);

    // Straddle starting at upper halfword
    clear = 1'b1;
    clear_half = 1'b1;
    tick();
    clear = 1'b0;
    clear_half = 1'b0;
    push_word(32'h0093_0001);
    tick();
    @(negedge clk);
    chk("straddle_wait_vld", 33'(ack_vld), 33'h0);
    chk("straddle_wait_cnt", 33'(count), 33'h1);
    sb.push_back({1'b1, 32'h0010_0093});
    sb.push_back({1'b0, 32'h0000_ABCD});
    req_vld = 1'b1;
    req_pld = 32'hABCD_0010;
    tick();
    req_vld = 1'b0;
    drain();
    chk("straddle_count0", 33'(count), 33'h0);

    // Backpressure: fill, hold an extra word off, pop one
    ack_rdy = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      req_vld = 1'b1;
      req_pld = 32'hA000_0003 | (32'(i) << 8);
      sb.push_back({1'b1, 32'hA000_0003 | (32'(i) << 8)});
      tick();
    end
    req_pld = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("full_req_rdy", 33'(req_rdy), 33'h0);
    chk("full_count", 33'(count), 33'(DEPTH));
    tick();
    req_vld = 1'b0;
    ack_rdy = 1'b1;
    tick();
    ack_rdy = 1'b0;
    @(negedge clk);
    chk("after_pop_req_rdy", 33'(req_rdy), 33'h1);
    chk("after_pop_count", 33'(count), 33'(DEPTH - 1));
    ack_rdy = 1'b1;
    drain();

    // Flush collision with rd_half previously set
    ack_rdy = 1'b0;
    clear = 1'b1;
    clear_half = 1'b1;
    tick();
    clear = 1'b0;
    clear_half = 1'b0;
    push_word(32'h1111_1113);
    push_word(32'h2222_2223);
    push_word(32'h3333_3333);
    @(negedge clk);
    chk("flush_pre_count", 33'(count), 33'h3);
    clear = 1'b1;
    clear_half = 1'b0;
    req_vld = 1'b1;
    req_pld = 32'h4444_4443;
    ack_rdy = 1'b1;
    #1;
    chk("flush_cycle_ack_vld", 33'(ack_vld), 33'h0);
    tick();
    clear = 1'b0;
    req_vld = 1'b0;
    @(negedge clk);
    chk("flush_count", 33'(count), 33'h0);
    chk("flush_ack_vld", 33'(ack_vld), 33'h0);
    sb.push_back({1'b1, 32'h0000_0013});
    @(posedge clk);
    #1;
    push_word(32'h0000_0013);
    drain();

    // Asynchronous reset mid-stream
    ack_rdy = 1'b0;
    for (int i = 0; i < 5; i++) push_word(32'h5555_0003 + (32'(i) << 4));
    @(negedge clk);
    chk("prereset_count", 33'(count), 33'h5);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_req_rdy", 33'(req_rdy), 33'h1);
    chk("arst_ack_vld", 33'(ack_vld), 33'h0);
    chk("arst_ack_pld", 33'(ack_pld), 33'h0);
    chk("arst_ack_len", 33'(ack_len), 33'h0);
    chk("arst_count",   33'(count),   33'h0);
    tick();
    rst_n = 1'b1;
    ack_rdy = 1'b1;
    sb.push_back({1'b1, 32'h0020_8093});
    push_word(32'h0020_8093);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
